// File: rtl/ats_eligibility_calc_if.sv
// Bundle of descriptor, flow-entry-manager and result signals for the ATS
// eligibility engine. The engine connects through the slave modport; the
// surrounding pipeline (descriptor source, manager, queue stage) uses master.
interface ats_eligibility_calc_if #(
    parameter int unsigned TIME_WIDTH = 59
);
    // descriptor handshake
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_flow_id;
    logic [3:0]            in_group_id;
    logic [15:0]           in_frame_len;
    logic [TIME_WIDTH-1:0] in_arrival_time;

    // flow entry manager lookup / write-back
    logic [31:0]           em_flow_id;
    logic [3:0]            em_group_id;
    logic                  em_start_match_flag;
    logic                  em_update_flag;
    logic [TIME_WIDTH-1:0] em_update_bucket_empty_time;
    logic [TIME_WIDTH-1:0] em_update_group_eligibility_time;
    logic                  em_match_finish_flag;
    logic [31:0]           em_bucket_size;
    logic [31:0]           em_token_rate;
    logic [TIME_WIDTH-1:0] em_bucket_empty_time;
    logic [TIME_WIDTH-1:0] em_group_eligibility_time;
    logic [TIME_WIDTH-1:0] em_max_residence_time;

    // result handshake
    logic                  out_valid;
    logic                  out_ready;
    logic [TIME_WIDTH-1:0] out_eligibility_time;
    logic                  out_discard;
    logic [31:0]           out_flow_id;
    logic [3:0]            out_group_id;

    logic                  err_timeout;

    modport slave (
        input  in_valid, in_flow_id, in_group_id, in_frame_len, in_arrival_time,
        output in_ready,
        output em_flow_id, em_group_id, em_start_match_flag, em_update_flag,
        output em_update_bucket_empty_time, em_update_group_eligibility_time,
        input  em_match_finish_flag, em_bucket_size, em_token_rate,
        input  em_bucket_empty_time, em_group_eligibility_time, em_max_residence_time,
        output out_valid, out_eligibility_time, out_discard, out_flow_id, out_group_id,
        input  out_ready,
        output err_timeout
    );

    modport master (
        output in_valid, in_flow_id, in_group_id, in_frame_len, in_arrival_time,
        input  in_ready,
        input  em_flow_id, em_group_id, em_start_match_flag, em_update_flag,
        input  em_update_bucket_empty_time, em_update_group_eligibility_time,
        output em_match_finish_flag, em_bucket_size, em_token_rate,
        output em_bucket_empty_time, em_group_eligibility_time, em_max_residence_time,
        input  out_valid, out_eligibility_time, out_discard, out_flow_id, out_group_id,
        output out_ready,
        input  err_timeout
    );
endinterface

// File: rtl/ats_eligibility_calc.sv
// Per-frame ATS token-bucket eligibility-time engine. Accepts one descriptor at
// a time, looks up its flow entry, computes the eligibility time, writes the
// new bucket-empty / group-eligibility times back and emits the decision.
module ats_eligibility_calc #(
    parameter int unsigned TIME_WIDTH    = 59,
    parameter int unsigned RATE_FRAC     = 8,
    parameter int unsigned INIT_CYCLES   = 192,
    parameter int unsigned MATCH_TIMEOUT = 16
) (
    input logic                  clk,
    input logic                  reset,
    ats_eligibility_calc_if.slave bus
);
    localparam int unsigned PROD_W       = 64;
    localparam int unsigned GUARD_CYCLES = 2;
    localparam int unsigned CNT_W        = $clog2(INIT_CYCLES + MATCH_TIMEOUT + GUARD_CYCLES + 1);

    typedef enum logic [3:0] {
        WAIT_INIT,
        IDLE,
        LOOKUP,
        WAIT_MATCH,
        CALC1,
        CALC2,
        DECIDE,
        OUTPUT,
        GUARD
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;

    // registered descriptor
    logic [15:0]           frame_len;
    logic [TIME_WIDTH-1:0] arrival;

    // captured flow entry
    logic [31:0]           bucket_size;
    logic [31:0]           token_rate;
    logic [TIME_WIDTH-1:0] bet;
    logic [TIME_WIDTH-1:0] grp_et;
    logic [TIME_WIDTH-1:0] mrt;

    // pipeline intermediates
    logic [TIME_WIDTH-1:0] lrd;
    logic [TIME_WIDTH-1:0] e2f;
    logic [TIME_WIDTH-1:0] sched_time;
    logic [TIME_WIDTH-1:0] bft;
    logic [TIME_WIDTH-1:0] elig_time;

    // combinational datapath feeding the stage registers
    logic [PROD_W-1:0]     lrd_prod;
    logic [PROD_W-1:0]     e2f_prod;
    logic [TIME_WIDTH-1:0] sched_next;
    logic [TIME_WIDTH-1:0] bft_next;
    logic [TIME_WIDTH-1:0] elig_next;
    logic [TIME_WIDTH-1:0] deadline;
    logic [TIME_WIDTH-1:0] bet_next;
    logic                  discard_next;

    // Token-bucket arithmetic; all sums wrap at TIME_WIDTH bits.
    always_comb begin
        lrd_prod   = PROD_W'(frame_len) * PROD_W'(token_rate);
        e2f_prod   = PROD_W'(bucket_size) * PROD_W'(token_rate);

        sched_next = bet + lrd;
        bft_next   = bet + e2f;
        elig_next  = arrival;
        if (grp_et > elig_next) begin
            elig_next = grp_et;
        end
        if (sched_next > elig_next) begin
            elig_next = sched_next;
        end

        deadline     = arrival + mrt;
        discard_next = (mrt != '0) && (elig_time > deadline);
        // a bucket that filled past capacity only credits up to the full level
        bet_next     = (elig_time < bft) ? sched_time : (sched_time + elig_time - bft);
    end

    // Control FSM with registered outputs and datapath stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                                <= WAIT_INIT;
            cnt                                  <= '0;
            frame_len                            <= '0;
            arrival                              <= '0;
            bucket_size                          <= '0;
            token_rate                           <= '0;
            bet                                  <= '0;
            grp_et                               <= '0;
            mrt                                  <= '0;
            lrd                                  <= '0;
            e2f                                  <= '0;
            sched_time                           <= '0;
            bft                                  <= '0;
            elig_time                            <= '0;
            bus.in_ready                         <= 1'b0;
            bus.em_flow_id                       <= '0;
            bus.em_group_id                      <= '0;
            bus.em_start_match_flag              <= 1'b0;
            bus.em_update_flag                   <= 1'b0;
            bus.em_update_bucket_empty_time      <= '0;
            bus.em_update_group_eligibility_time <= '0;
            bus.out_valid                        <= 1'b0;
            bus.out_eligibility_time             <= '0;
            bus.out_discard                      <= 1'b0;
            bus.out_flow_id                      <= '0;
            bus.out_group_id                     <= '0;
            bus.err_timeout                      <= 1'b0;
        end else begin
            // single-cycle pulses default low
            bus.em_start_match_flag <= 1'b0;
            bus.em_update_flag      <= 1'b0;

            case (state)
                WAIT_INIT: begin
                    if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
                        cnt          <= '0;
                        bus.in_ready <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                IDLE: begin
                    if (bus.in_valid) begin
                        frame_len               <= bus.in_frame_len;
                        arrival                 <= bus.in_arrival_time;
                        bus.em_flow_id          <= bus.in_flow_id;
                        bus.em_group_id         <= bus.in_group_id;
                        bus.out_flow_id         <= bus.in_flow_id;
                        bus.out_group_id        <= bus.in_group_id;
                        bus.in_ready            <= 1'b0;
                        bus.em_start_match_flag <= 1'b1;
                        state                   <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    cnt   <= '0;
                    state <= WAIT_MATCH;
                end

                WAIT_MATCH: begin
                    if (bus.em_match_finish_flag) begin
                        bucket_size <= bus.em_bucket_size;
                        token_rate  <= bus.em_token_rate;
                        bet         <= bus.em_bucket_empty_time;
                        grp_et      <= bus.em_group_eligibility_time;
                        mrt         <= bus.em_max_residence_time;
                        state       <= CALC1;
                    end else if (cnt == CNT_W'(MATCH_TIMEOUT - 1)) begin
                        bus.err_timeout          <= 1'b1;
                        bus.out_discard          <= 1'b1;
                        bus.out_eligibility_time <= '0;
                        bus.out_valid            <= 1'b1;
                        state                    <= OUTPUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                CALC1: begin
                    lrd   <= TIME_WIDTH'(lrd_prod >> RATE_FRAC);
                    e2f   <= TIME_WIDTH'(e2f_prod >> RATE_FRAC);
                    state <= CALC2;
                end

                CALC2: begin
                    sched_time <= sched_next;
                    bft        <= bft_next;
                    elig_time  <= elig_next;
                    state      <= DECIDE;
                end

                DECIDE: begin
                    bus.out_valid            <= 1'b1;
                    bus.out_eligibility_time <= elig_time;
                    bus.out_discard          <= discard_next;
                    if (!discard_next) begin
                        bus.em_update_flag                   <= 1'b1;
                        bus.em_update_bucket_empty_time      <= bet_next;
                        bus.em_update_group_eligibility_time <= elig_time;
                    end
                    state <= OUTPUT;
                end

                OUTPUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= GUARD;
                    end
                end

                GUARD: begin
                    // lets the manager finish its write-back before the next lookup
                    if (cnt == CNT_W'(GUARD_CYCLES - 1)) begin
                        cnt          <= '0;
                        bus.in_ready <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= WAIT_INIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ats_eligibility_calc.sv
// Directed bench for ats_eligibility_calc with a simple flow-entry-manager model.
module tb_ats_eligibility_calc;
    localparam int unsigned TW = 59;

    typedef struct packed {
        logic [TW-1:0] bet;
        logic [TW-1:0] get;
        logic [TW-1:0] mrt;
        logic [TW-1:0] arrival;
        logic [TW-1:0] et;
        logic [TW-1:0] nbet;
        logic [TW-1:0] nget;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // manager model controls / observations
    bit mgr_respond = 1'b1;
    int mgr_delay = 3;
    int m_cyc = -1;

    // update / start monitor
    int            upd_count = 0;
    int            upd_cyc = -1;
    int            start_cyc = -1;
    logic [TW-1:0] upd_bet = '0;
    logic [TW-1:0] upd_get = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ats_eligibility_calc_if #(.TIME_WIDTH(TW)) bus ();

    ats_eligibility_calc #(
        .TIME_WIDTH(TW),
        .RATE_FRAC(8),
        .INIT_CYCLES(192),
        .MATCH_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    // manager: answers a start pulse after mgr_delay cycles with a 2-cycle finish flag
    initial begin
        bus.em_match_finish_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.em_start_match_flag && mgr_respond) begin
                repeat (mgr_delay) @(negedge clk);
                bus.em_match_finish_flag = 1'b1;
                m_cyc = cyc;
                @(negedge clk);
                @(negedge clk);
                bus.em_match_finish_flag = 1'b0;
            end
        end
    end

    // monitor of lookup starts and write-back pulses
    initial begin
        forever begin
            @(negedge clk);
            if (bus.em_update_flag === 1'b1) begin
                upd_count = upd_count + 1;
                upd_cyc   = cyc;
                upd_bet   = bus.em_update_bucket_empty_time;
                upd_get   = bus.em_update_group_eligibility_time;
            end
            if (bus.em_start_match_flag === 1'b1) start_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Presents one descriptor and returns at the negedge where out_valid first shows.
    task automatic run_frame(input logic [31:0] flow, input logic [3:0] grp,
                             input logic [TW-1:0] arrival, input logic [TW-1:0] bet,
                             input logic [TW-1:0] get, input logic [TW-1:0] mrt,
                             output bit seen, output int ov_cyc);
        int n;
        bus.em_bucket_size            = 32'd3200;
        bus.em_token_rate             = 32'd8000;
        bus.em_bucket_empty_time      = bet;
        bus.em_group_eligibility_time = get;
        bus.em_max_residence_time     = mrt;
        m_cyc = -1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        bus.in_flow_id      = flow;
        bus.in_group_id     = grp;
        bus.in_frame_len    = 16'd1000;
        bus.in_arrival_time = arrival;
        bus.in_valid        = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        ov_cyc = cyc;
    endtask

    // Releases the result and waits for out_valid to drop plus the guard window.
    task automatic drain();
        int n;
        bus.out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.out_valid === 1'b1 && n < 50);
        repeat (2) @(negedge clk);
    endtask

    // Counts cycles with in_ready low starting at the current negedge.
    task automatic count_init(output int n);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.err_timeout !== 1'b0) begin
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b err_timeout=%b, want 0 0 0",
                     bus.in_ready, bus.out_valid, bus.err_timeout);
            mismatched++;
        end
        compared++;
        if (bus.em_start_match_flag !== 1'b0 || bus.em_update_flag !== 1'b0 || bus.out_discard !== 1'b0) begin
            $display("FAIL reset_flags: start=%b update=%b discard=%b, want 0 0 0",
                     bus.em_start_match_flag, bus.em_update_flag, bus.out_discard);
            mismatched++;
        end
        compared++;
        if (bus.out_eligibility_time !== '0 || bus.em_flow_id !== '0 || bus.out_flow_id !== '0 ||
            bus.em_update_bucket_empty_time !== '0 || bus.em_update_group_eligibility_time !== '0) begin
            $display("FAIL reset_data: out_et=%0d em_flow=%h out_flow=%h upd_bet=%0d upd_get=%0d, want all 0",
                     bus.out_eligibility_time, bus.em_flow_id, bus.out_flow_id,
                     bus.em_update_bucket_empty_time, bus.em_update_group_eligibility_time);
            mismatched++;
        end
        reset = 1'b0;
        count_init(n);
        compared++;
        if (n != 192) begin
            $display("FAIL reset_init_len: in_ready low for %0d cycles, want 192", n);
            mismatched++;
        end
    endtask

    task automatic test_eligibility();
        vec_t          v[5];
        logic [TW-1:0] wrap_bet;
        bit            seen;
        int            ov_cyc;
        int            u0;
        wrap_bet = '1;
        wrap_bet = wrap_bet - TW'(999);
        //            bet       get       mrt       arrival   et        new bet   new get
        v[0] = '{TW'(0),  TW'(0),     TW'(0),     TW'(10000),  TW'(31250),  TW'(31250),  TW'(31250)};
        v[1] = '{TW'(0),  TW'(0),     TW'(0),     TW'(200000), TW'(200000), TW'(131250), TW'(200000)};
        v[2] = '{TW'(0),  TW'(90000), TW'(0),     TW'(10000),  TW'(90000),  TW'(31250),  TW'(90000)};
        v[3] = '{TW'(0),  TW'(0),     TW'(21250), TW'(10000),  TW'(31250),  TW'(31250),  TW'(31250)};
        v[4] = '{wrap_bet, TW'(0),    TW'(0),     TW'(0),      TW'(30250),  TW'(30250),  TW'(30250)};
        for (int i = 0; i < 5; i++) begin
            u0 = upd_count;
            run_frame(32'hA000_0000 + 32'(i), 4'(i + 1), v[i].arrival, v[i].bet, v[i].get, v[i].mrt,
                      seen, ov_cyc);
            compared++;
            if (!seen) begin
                $display("FAIL elig[%0d] out_valid: never seen, want asserted", i);
                mismatched++;
            end
            compared++;
            if (bus.out_eligibility_time !== v[i].et || bus.out_discard !== 1'b0) begin
                $display("FAIL elig[%0d] result: et=%0d discard=%b, want et=%0d discard=0",
                         i, bus.out_eligibility_time, bus.out_discard, v[i].et);
                mismatched++;
            end
            compared++;
            if (bus.out_flow_id !== 32'hA000_0000 + 32'(i) || bus.out_group_id !== 4'(i + 1) ||
                bus.em_flow_id !== 32'hA000_0000 + 32'(i) || bus.em_group_id !== 4'(i + 1)) begin
                $display("FAIL elig[%0d] key_echo: out=%h/%0d em=%h/%0d, want %h/%0d", i,
                         bus.out_flow_id, bus.out_group_id, bus.em_flow_id, bus.em_group_id,
                         32'hA000_0000 + 32'(i), i + 1);
                mismatched++;
            end
            compared++;
            if (ov_cyc != m_cyc + 4) begin
                $display("FAIL elig[%0d] latency: out_valid at M+%0d, want M+4", i, ov_cyc - m_cyc);
                mismatched++;
            end
            drain();
            compared++;
            if (upd_count - u0 != 1 || upd_cyc != m_cyc + 4) begin
                $display("FAIL elig[%0d] update_pulse: count=%0d at M+%0d, want 1 at M+4",
                         i, upd_count - u0, upd_cyc - m_cyc);
                mismatched++;
            end
            compared++;
            if (upd_bet !== v[i].nbet || upd_get !== v[i].nget) begin
                $display("FAIL elig[%0d] update_value: bet=%0d get=%0d, want bet=%0d get=%0d",
                         i, upd_bet, upd_get, v[i].nbet, v[i].nget);
                mismatched++;
            end
        end
    endtask

    task automatic test_discard();
        bit seen;
        int ov_cyc;
        int u0;
        u0 = upd_count;
        run_frame(32'h0000_0005, 4'd5, TW'(10000), TW'(50000), TW'(0), TW'(1000), seen, ov_cyc);
        compared++;
        if (!seen || bus.out_discard !== 1'b1 || bus.out_eligibility_time !== TW'(81250)) begin
            $display("FAIL discard_result: seen=%0d discard=%b et=%0d, want 1 1 81250",
                     seen, bus.out_discard, bus.out_eligibility_time);
            mismatched++;
        end
        drain();
        compared++;
        if (upd_count != u0) begin
            $display("FAIL discard_no_update: %0d pulses, want 0", upd_count - u0);
            mismatched++;
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int ov_cyc;
        int n;
        int u0;
        run_frame(32'h0000_0011, 4'd1, TW'(10000), TW'(0), TW'(0), TW'(0), seen, ov_cyc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.in_ready !== 1'b1 && n < 20);
        compared++;
        if (n != 3) begin
            $display("FAIL b2b_gap: in_ready after %0d cycles, want 3", n);
            mismatched++;
        end
        u0 = upd_count;
        run_frame(32'h0000_0012, 4'd2, TW'(10000), TW'(0), TW'(90000), TW'(0), seen, ov_cyc);
        compared++;
        if (!seen || bus.out_eligibility_time !== TW'(90000) || bus.out_flow_id !== 32'h0000_0012) begin
            $display("FAIL b2b_second: seen=%0d et=%0d flow=%h, want 1 90000 00000012",
                     seen, bus.out_eligibility_time, bus.out_flow_id);
            mismatched++;
        end
        drain();
        compared++;
        if (upd_count - u0 != 1 || upd_bet !== TW'(31250) || upd_get !== TW'(90000)) begin
            $display("FAIL b2b_update: count=%0d bet=%0d get=%0d, want 1 31250 90000",
                     upd_count - u0, upd_bet, upd_get);
            mismatched++;
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int ov_cyc;
        int u0;
        mgr_respond = 1'b0;
        u0 = upd_count;
        run_frame(32'h0000_0077, 4'd7, TW'(10000), TW'(0), TW'(0), TW'(0), seen, ov_cyc);
        compared++;
        if (!seen || ov_cyc - start_cyc != 17) begin
            $display("FAIL timeout_latency: seen=%0d out_valid at start+%0d, want start+17",
                     seen, ov_cyc - start_cyc);
            mismatched++;
        end
        compared++;
        if (bus.out_discard !== 1'b1 || bus.out_eligibility_time !== '0 || bus.err_timeout !== 1'b1) begin
            $display("FAIL timeout_result: discard=%b et=%0d err=%b, want 1 0 1",
                     bus.out_discard, bus.out_eligibility_time, bus.err_timeout);
            mismatched++;
        end
        drain();
        mgr_respond = 1'b1;
        compared++;
        if (upd_count != u0) begin
            $display("FAIL timeout_no_update: %0d pulses, want 0", upd_count - u0);
            mismatched++;
        end
    endtask

    task automatic test_backpressure();
        bit            seen;
        int            ov_cyc;
        int            u0;
        int            unstable;
        logic [TW-1:0] et0;
        u0 = upd_count;
        bus.out_ready = 1'b0;
        run_frame(32'h0000_0099, 4'd9, TW'(200000), TW'(0), TW'(0), TW'(0), seen, ov_cyc);
        et0 = bus.out_eligibility_time;
        compared++;
        if (!seen || et0 !== TW'(200000)) begin
            $display("FAIL bp_result: seen=%0d et=%0d, want 1 200000", seen, et0);
            mismatched++;
        end
        unstable = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_eligibility_time !== et0 ||
                bus.out_discard !== 1'b0 || bus.out_flow_id !== 32'h0000_0099 ||
                bus.out_group_id !== 4'd9) unstable++;
        end
        compared++;
        if (unstable != 0) begin
            $display("FAIL bp_stable: %0d unstable cycles, want 0", unstable);
            mismatched++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL bp_release: out_valid=%b after handshake, want 0", bus.out_valid);
            mismatched++;
        end
        repeat (3) @(negedge clk);
        compared++;
        if (upd_count - u0 != 1 || upd_bet !== TW'(131250) || upd_get !== TW'(200000)) begin
            $display("FAIL bp_update: count=%0d bet=%0d get=%0d, want 1 131250 200000",
                     upd_count - u0, upd_bet, upd_get);
            mismatched++;
        end
        compared++;
        if (bus.err_timeout !== 1'b1) begin
            $display("FAIL bp_err_sticky: err_timeout=%b, want 1", bus.err_timeout);
            mismatched++;
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        int u0;
        u0 = upd_count;
        mgr_delay = 2;
        bus.em_bucket_empty_time      = TW'(0);
        bus.em_group_eligibility_time = TW'(0);
        bus.em_max_residence_time     = TW'(0);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        bus.in_flow_id      = 32'h0000_00AA;
        bus.in_group_id     = 4'd3;
        bus.in_arrival_time = TW'(10000);
        bus.in_valid        = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.em_match_finish_flag !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_init(n);
        compared++;
        if (n != 192) begin
            $display("FAIL midreset_init_len: in_ready low for %0d cycles, want 192", n);
            mismatched++;
        end
        compared++;
        if (upd_count != u0 || bus.out_valid !== 1'b0) begin
            $display("FAIL midreset_abort: %0d update pulses, out_valid=%b, want 0 0",
                     upd_count - u0, bus.out_valid);
            mismatched++;
        end
        compared++;
        if (bus.err_timeout !== 1'b0) begin
            $display("FAIL midreset_err_clear: err_timeout=%b, want 0", bus.err_timeout);
            mismatched++;
        end
        mgr_delay = 3;
    endtask

    initial begin
        bus.in_valid                  = 1'b0;
        bus.in_flow_id                = '0;
        bus.in_group_id               = '0;
        bus.in_frame_len              = 16'd1000;
        bus.in_arrival_time           = '0;
        bus.out_ready                 = 1'b1;
        bus.em_bucket_size            = 32'd3200;
        bus.em_token_rate             = 32'd8000;
        bus.em_bucket_empty_time      = '0;
        bus.em_group_eligibility_time = '0;
        bus.em_max_residence_time     = '0;

        test_reset();
        test_eligibility();
        test_discard();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_reset_mid_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ats_eligibility_calc.md
# ats_eligibility_calc

Per-frame ATS (802.1Qcr token-bucket) eligibility-time engine, sitting directly downstream of `flow_entry_manager`. For each accepted frame descriptor it:
- starts a flow-entry lookup;
- computes the eligibility time from the returned bucket and group state;
- writes the updated bucket-empty and group-eligibility times back through the manager's update port;
- emits an eligibility/discard decision to the queue stage.

## Interface
- TIME_WIDTH, 59, timestamp width; all time arithmetic is modulo 2^TIME_WIDTH.
- RATE_FRAC, 8, fractional bits of `token_rate`, which is time units per byte in fixed point.
- INIT_CYCLES, 192, post-reset cycles to wait while the manager initialises its RAM.
- MATCH_TIMEOUT, 16, maximum cycles from start pulse to `em_match_finish_flag`.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid / in_ready  in / out  1 / 1  descriptor handshake.
- in_flow_id  in  32  flow id; bits [3:0] select the entry.
- in_group_id  in  4  group.
- in_frame_len  in  16  frame length in bytes.
- in_arrival_time  in  TIME_WIDTH  arrival timestamp.
- em_flow_id, em_group_id  out  32, 4  lookup/update key to the manager.
- em_start_match_flag  out  1  one-cycle lookup pulse.
- em_update_flag  out  1  one-cycle write-back pulse.
- em_update_bucket_empty_time, em_update_group_eligibility_time  out  TIME_WIDTH  write-back values.
- em_match_finish_flag  in  1  lookup done; high for 2 cycles.
- em_bucket_size  in  32  bucket size in bytes.
- em_token_rate  in  32  token rate.
- em_bucket_empty_time, em_group_eligibility_time, em_max_residence_time  in  TIME_WIDTH  entry state.
- out_valid / out_ready  out / in  1 / 1  result handshake.
- out_eligibility_time  out  TIME_WIDTH  computed eligibility time.
- out_discard  out  1  frame must be dropped.
- out_flow_id, out_group_id  out  32, 4  echo of the key.
- err_timeout  out  1  sticky flag; set when a lookup times out.

## Operation
- **States:** WAIT_INIT → IDLE → LOOKUP → WAIT_MATCH → CALC1 → CALC2 → DECIDE → OUTPUT → GUARD → IDLE.
- **WAIT_INIT:** count INIT_CYCLES; `in_ready`=0.
- **IDLE:** `in_ready`=1. On `in_valid`, register the descriptor and drive `em_flow_id`/`em_group_id`. These stay stable until GUARD exits.
- **LOOKUP:** `em_start_match_flag`=1 for exactly one cycle, then go to WAIT_MATCH.
- **WAIT_MATCH:**
  - On the first cycle with `em_match_finish_flag`=1, capture all `em_*` entry inputs and go to CALC1. The second flag-high cycle is ignored.
  - After MATCH_TIMEOUT cycles with no flag: set `err_timeout`, set `out_discard`=1 and `out_eligibility_time`=0, and go to OUTPUT with no update.
- **CALC1:** register the two products:
  - LRD = (frame_len × token_rate) >> RATE_FRAC
  - E2F = (bucket_size × token_rate) >> RATE_FRAC
  - Full-width products, zero-extended to TIME_WIDTH.
- **CALC2:**
  - SET = BET + LRD
  - BFT = BET + E2F
  - ET = max(arrival, GET, SET), unsigned compare.
- **DECIDE:**
  - If MRT≠0 and ET > arrival+MRT: discard.
  - Otherwise: new GET = ET; new BET = (ET < BFT) ? SET : SET + ET − BFT.
- **OUTPUT:**
  - `out_valid`=1 holding the result.
  - If not discarded, `em_update_flag`=1 in the first OUTPUT cycle only, carrying the new BET/GET.
  - Exit when `out_ready`=1.
- **GUARD:** 2 cycles, covering the manager's UPDATING→IDLE sequence, then IDLE.
- **Busy behaviour:** the block is single-outstanding; `in_ready`=0 in every state except IDLE.

## Timing
- **Reset values:** all outputs 0, including `err_timeout`; state = WAIT_INIT.
- **Reset mid-operation:** aborts immediately. No update pulse issues, and the block re-enters WAIT_INIT.
- **Latency:** with M = the first cycle `em_match_finish_flag` is high, CALC1=M+1, CALC2=M+2, DECIDE=M+3, OUTPUT starts at M+4.
  - The update pulse is in cycle M+4. The flag has been low since M+2, so the manager is in IDLE.
- **Back-to-back:** minimum 3 cycles from `out_valid`&`out_ready` to the next `in_ready`.
- **Outputs:** `out_*` stay stable while `out_valid`=1 and `out_ready`=0.
- **Update pulse:** asserted at most once per frame, even under backpressure.
- **Timeout:** counted from the cycle after the start pulse.
- **Arithmetic:** sums wrap modulo 2^TIME_WIDTH with no saturation; arrival+MRT wraps the same way.

## Test plan
All scenarios use bucket_size=3200, token_rate=8000, len=1000, so LRD=31250 and E2F=100000.
- **Eligibility from bucket:** BET=0, GET=0, MRT=0, arrival=10000 → ET=31250, no discard; update pulse with BET=31250, GET=31250.
- **Bucket full:** as above but arrival=200000 → ET=200000; update BET=131250, GET=200000.
- **Group dominates:** GET=90000, BET=0, arrival=10000 → ET=90000; update BET=31250, GET=90000.
- **Discard:** MRT=1000, BET=50000, arrival=10000 → ET=81250 > 11000 → `out_discard`=1; no `em_update_flag` seen.
- **Timeout:** manager model never raises the finish flag → `out_valid` with `out_discard`=1 at start+17, `err_timeout`=1, no update.
- **Backpressure and reset:**
  - Holding `out_ready`=0 for 5 cycles keeps outputs stable and gives exactly one update pulse.
  - Reset asserted in CALC2 produces no update pulse and holds `in_ready` low for 192 cycles.
